// File: rtl/int2float_seq_pkg.sv
// float_pkg: shared float field layout, constants and FSM state encoding for int2float_seq / float2int
package float_pkg;
  localparam int FLT_BIAS  = 127;
  localparam int FLT_EXP_W = 8;
  localparam int FLT_MAN_W = 23;
  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;
  typedef struct packed {
    logic                 sign;
    logic [FLT_EXP_W-1:0] exponent;
    logic [FLT_MAN_W-1:0] mantissa;
  } float_fields_t;
endpackage

// File: rtl/int2float_seq_round.sv
// int2float_round: aligns a normalized magnitude fraction into a 23-bit mantissa, with sticky and optional RNE
// Ports: sign/frac/exp_in = sign, fraction below the hidden bit, exponent; fields = packed result; inexact = dropped bits nonzero.
// Rounding is compiled in only with INT2FLOAT_ROUND_EN defined; otherwise truncates toward zero.
module int2float_round
  import float_pkg::*;
#(
  parameter int INT_W = 31
) (
  input  logic                 sign,
  input  logic [INT_W-2:0]     frac,
  input  logic [FLT_EXP_W-1:0] exp_in,
  output float_fields_t        fields,
  output logic                 inexact
);
  // Appending 23 zeros lets one slice cover both the pad (narrow) and truncate (wide) cases.
  logic [INT_W+21:0]     ext;
  logic [FLT_MAN_W-1:0]  man;
  logic [INT_W-2:0]      rest;
  assign ext     = {frac, {FLT_MAN_W{1'b0}}};
  assign man     = ext[INT_W+21 -: FLT_MAN_W];
  assign rest    = ext[INT_W-2:0];
  assign inexact = |rest;
`ifdef INT2FLOAT_ROUND_EN
  logic             up;
  logic [FLT_MAN_W:0] sum;
  // rest msb is the guard bit; everything below it is sticky
  assign up     = rest[INT_W-2] && ((|(rest << 1)) || man[0]);
  assign sum    = {1'b0, man} + (FLT_MAN_W+1)'(up);
  assign fields = {sign, exp_in + FLT_EXP_W'(sum[FLT_MAN_W]), sum[FLT_MAN_W-1:0]};
`else
  assign fields = {sign, exp_in, man};
`endif
endmodule

// File: rtl/int2float_seq.sv
// int2float_seq: sequential sign-magnitude integer to IEEE-754 single converter, one normalize shift per cycle
// Ports: clk/rst (sync, active high); in_valid/in_ready/sign_in/int_in input handshake;
// out_valid/out_ready/sign_out/exponent_out/mantissa_out/inexact output handshake.
// Optional macro INT2FLOAT_ROUND_EN enables round-to-nearest-even in int2float_round.
module int2float_seq
  import float_pkg::*;
#(
  parameter int INT_W = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign_in,
  input  logic [INT_W-1:0]     int_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sign_out,
  output logic [FLT_EXP_W-1:0] exponent_out,
  output logic [FLT_MAN_W-1:0] mantissa_out,
  output logic                 inexact
);
  localparam logic [FLT_EXP_W-1:0] EXP_MAX = FLT_EXP_W'(FLT_BIAS + INT_W - 1);
  state_t               state;
  logic [INT_W-1:0]     work_reg;
  logic [FLT_EXP_W-1:0] exp_reg;
  logic                 sign_reg;
  float_fields_t        rnd;
  logic                 rnd_inexact;
  int2float_round #(.INT_W(INT_W)) u_round (
    .sign   (sign_reg),
    .frac   (work_reg[INT_W-2:0]),
    .exp_in (exp_reg),
    .fields (rnd),
    .inexact(rnd_inexact)
  );
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      work_reg     <= '0;
      exp_reg      <= '0;
      sign_reg     <= 1'b0;
      sign_out     <= 1'b0;
      exponent_out <= '0;
      mantissa_out <= '0;
      inexact      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sign_reg <= sign_in;
          work_reg <= int_in;
          exp_reg  <= EXP_MAX;
          if (int_in == '0) begin
            state        <= DONE;
            sign_out     <= sign_in;
            exponent_out <= '0;
            mantissa_out <= '0;
            inexact      <= 1'b0;
          end else state <= NORM;
        end
        NORM: if (!work_reg[INT_W-1]) begin
          work_reg <= work_reg << 1;
          exp_reg  <= exp_reg - 1'b1;
        end else begin
          {sign_out, exponent_out, mantissa_out} <= rnd;
          inexact <= rnd_inexact;
          state   <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/int2float_seq.md
Name: int2float_seq

Overview:
- Sequential sign-magnitude integer to IEEE-754 single-precision converter. It is the inverse of the float2int converter.
- Input format: sign bit plus an INT_W-bit magnitude. Output format: sign, 8-bit biased exponent and 23-bit mantissa, split into the same fields float2int consumes.
- Normalizes iteratively, shifting one bit per cycle, behind valid/ready handshakes on both sides.
- Sits between integer datapaths and float consumers; the float2int → int2float_seq loopback is the regression path.

Parameters:
- INT_W, 31, magnitude width; legal range 2..31. Maximum exponent is 127+INT_W-1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word; high only in IDLE.
- sign_in  in  1  sign of input (1 = negative).
- int_in  in  INT_W  unsigned magnitude.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- sign_out  out  1  result sign.
- exponent_out  out  8  biased exponent (bias 127).
- mantissa_out  out  23  fraction without the hidden bit.
- inexact  out  1  nonzero magnitude bits were discarded.

Behaviour:
- Reset: state=IDLE; in_ready=1; out_valid=0; sign_out=0; exponent_out=0; mantissa_out=0; inexact=0. A reset in any state aborts the operation in flight with no output.
- States:
  - IDLE: in_ready=1. On in_valid && in_ready, capture sign_in, load work_reg=int_in and exp_reg=127+INT_W-1.
    - If int_in==0: go to DONE with exponent_out=0, mantissa_out=0, inexact=0, sign_out=sign_in (-0 is preserved).
    - Otherwise go to NORM.
  - NORM: in_ready=0.
    - If work_reg[INT_W-1]==0: work_reg shifts left by 1 and exp_reg decrements by 1.
    - Else build the result and go to DONE. The fraction is work_reg[INT_W-2:0], left-aligned into 23 bits and zero-padded when INT_W-1<23.
    - If INT_W-1>23, the low INT_W-24 bits are truncated and inexact = OR of those bits.
  - DONE: out_valid=1. All outputs are held stable while out_ready=0. On out_ready, go to IDLE; out_valid drops next cycle. Output registers keep their last value after leaving DONE.
- Latency, with accept at cycle T:
  - Zero input: out_valid is first high at T+1.
  - Nonzero input: out_valid is first high at T+2+lz, where lz = leading zeros of int_in within INT_W.
- Throughput: no overlap between words; the next accept happens no earlier than the cycle after the DONE handshake.
- Overflow is impossible, since the maximum exponent is ≤157. Negative magnitudes are never seen; sign is carried through unchanged.

Optional Feature:
- Macro: INT2FLOAT_ROUND_EN.
- Defined: round-to-nearest-even on the truncated bits, applied in the NORM→DONE transition cycle. Latency is unchanged.
  - If mantissa rounding carries out, mantissa_out=0 and exponent_out=exp_reg+1.
  - inexact has the same meaning as without the macro.
- Undefined: truncate toward zero; no rounding logic is present.
- The macro has no effect when INT_W≤24.

Decomposition:
- Package float_pkg holds:
  - constants FLT_BIAS=127, FLT_EXP_W=8, FLT_MAN_W=23;
  - typedef state_t {IDLE, NORM, DONE};
  - a packed struct float_fields_t {sign, exponent, mantissa}, shared with float2int.
- One sub-module, int2float_round: combinational alignment, truncation, sticky and RNE logic, taking the normalized work_reg and exp_reg. The FSM stays in the top module.

Test Plan:
- Small value: int_in=3, sign_in=0, INT_W=31, out_ready=1 → exponent_out=0x80, mantissa_out=0x400000, inexact=0. out_valid first high 31 cycles after the accept (lz=29).
- Typical value: int_in=100 → exp 0x85, mant 0x480000. Then int_in=1000000 with sign_in=1 → sign 1, exp 0x92, mant 0x742400.
- Zero: int_in=0, sign_in=1 → out_valid at T+1, sign_out=1, exp 0, mant 0.
- Truncation/rounding: int_in=0x7FFFFFFF →
  - macro undefined: exp 0x9D, mant 0x7FFFFF, inexact=1;
  - INT2FLOAT_ROUND_EN defined: exp 0x9E, mant 0, inexact=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid stays 1, outputs stable, in_ready=0, and in_valid pulses are ignored. On release, exactly one handshake, then IDLE.
- Reset mid-operation: assert rst during NORM on int_in=1 → next cycle IDLE, in_ready=1, out_valid=0. A fresh input of 100 then converts correctly.
